// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts fetch addresses, delays them through a fixed
// latency pipeline and returns FETCH_WIDTH consecutive words per request, in order.
module imem_responder #(
    parameter int CPU_ADDR_BITS = 32,
    parameter int CPU_INST_BITS = 32,
    parameter int FETCH_WIDTH   = 2,
    parameter int DEPTH         = 1024,
    parameter int LATENCY       = 2,
    parameter int MAX_OUT       = 4,
    localparam int IDX_BITS     = $clog2(DEPTH)
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_flush,
    input  logic                               i_imem_req_val,
    output logic                               o_imem_req_rdy,
    input  logic [CPU_ADDR_BITS-1:0]           i_imem_req_packet,
    output logic                               o_imem_rec_val,
    input  logic                               i_imem_rec_rdy,
    output logic [FETCH_WIDTH*CPU_INST_BITS-1:0] o_imem_rec_packet,
    input  logic                               i_ld_we,
    input  logic [IDX_BITS-1:0]                i_ld_addr,
    input  logic [CPU_INST_BITS-1:0]           i_ld_data
);

    localparam int PKT_BITS = FETCH_WIDTH * CPU_INST_BITS;
    localparam int PTR_BITS = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CNT_BITS = $clog2(MAX_OUT + 1);

    logic [CPU_INST_BITS-1:0] r_mem [DEPTH];

    logic [LATENCY-1:0]  r_pipeVal;
    logic [IDX_BITS-1:0] r_pipeIdx [LATENCY];

    logic [PKT_BITS-1:0] r_fifo [MAX_OUT];
    logic [PTR_BITS-1:0] r_wrPtr;
    logic [PTR_BITS-1:0] r_rdPtr;
    logic [CNT_BITS-1:0] r_fifoCnt;
    logic [CNT_BITS-1:0] r_outCnt;

    logic                w_accept;
    logic                w_deliver;
    logic                w_push;
    logic [IDX_BITS-1:0] w_reqIdx;
    logic [PKT_BITS-1:0] w_readPkt;
    logic [CPU_ADDR_BITS-IDX_BITS-1:0] w_unusedAddrBits;

    // Outstanding count covers pipeline plus FIFO, so bounding it also bounds the FIFO.
    assign o_imem_req_rdy   = i_rst && !i_flush && (r_outCnt < CNT_BITS'(MAX_OUT));
    assign w_accept         = i_imem_req_val && o_imem_req_rdy;
    assign w_deliver        = o_imem_rec_val && i_imem_rec_rdy;
    assign w_push           = r_pipeVal[LATENCY-1];
    assign w_reqIdx         = i_imem_req_packet[2 +: IDX_BITS];
    assign w_unusedAddrBits = {i_imem_req_packet[CPU_ADDR_BITS-1:IDX_BITS+2],
                               i_imem_req_packet[1:0]};

    assign o_imem_rec_val    = (r_fifoCnt != '0);
    assign o_imem_rec_packet = o_imem_rec_val ? r_fifo[r_rdPtr] : '0;

    always_ff @(posedge i_clk) begin
        if (i_ld_we) begin
            r_mem[i_ld_addr] <= i_ld_data;
        end
    end

    // Index addition wraps naturally at IDX_BITS, giving mod-DEPTH slot addressing.
    always_comb begin
        w_readPkt = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            w_readPkt[i*CPU_INST_BITS +: CPU_INST_BITS] =
                r_mem[r_pipeIdx[LATENCY-1] + IDX_BITS'(i)];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_pipeVal <= '0;
        end else if (i_flush) begin
            r_pipeVal <= '0;
        end else begin
            r_pipeVal[0] <= w_accept;
            for (int s = 1; s < LATENCY; s++) begin
                r_pipeVal[s] <= r_pipeVal[s-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        r_pipeIdx[0] <= w_reqIdx;
        for (int s = 1; s < LATENCY; s++) begin
            r_pipeIdx[s] <= r_pipeIdx[s-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo[r_wrPtr] <= w_readPkt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_fifoCnt <= '0;
        end else if (i_flush) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_fifoCnt <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= (r_wrPtr == PTR_BITS'(MAX_OUT - 1)) ? '0 : r_wrPtr + PTR_BITS'(1);
            end
            if (w_deliver) begin
                r_rdPtr <= (r_rdPtr == PTR_BITS'(MAX_OUT - 1)) ? '0 : r_rdPtr + PTR_BITS'(1);
            end
            case ({w_push, w_deliver})
                2'b10:   r_fifoCnt <= r_fifoCnt + CNT_BITS'(1);
                2'b01:   r_fifoCnt <= r_fifoCnt - CNT_BITS'(1);
                default: r_fifoCnt <= r_fifoCnt;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_outCnt <= '0;
        end else if (i_flush) begin
            r_outCnt <= '0;
        end else begin
            case ({w_accept, w_deliver})
                2'b10:   r_outCnt <= r_outCnt + CNT_BITS'(1);
                2'b01:   r_outCnt <= r_outCnt - CNT_BITS'(1);
                default: r_outCnt <= r_outCnt;
            endcase
        end
    end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder that terminates the core's IMEM request/response ports and returns FETCH_WIDTH consecutive instruction words per accepted fetch address. Requests are accepted with a valid/ready handshake, delayed through a fixed-latency pipeline, and buffered in an in-order response FIFO drained by the core's fetch stage. A flush input discards all in-flight and buffered responses on a fetch redirect. A side-band load port initialises the backing array.

## Interface
- CPU_ADDR_BITS, 32, byte-address width
- CPU_INST_BITS, 32, instruction word width
- FETCH_WIDTH, 2, words returned per request
- DEPTH, 1024, backing array size in words (power of two)
- LATENCY, 2, cycles from request accept to earliest response valid (>=1)
- MAX_OUT, 4, max outstanding requests (accepted, not yet delivered)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  discard all outstanding requests and responses
- imem_req_val  in  1  request valid
- imem_req_rdy  out  1  responder can accept a request
- imem_req_packet  in  CPU_ADDR_BITS  fetch byte address
- imem_rec_val  out  1  response valid
- imem_rec_rdy  in  1  core accepts response
- imem_rec_packet  out  FETCH_WIDTH*CPU_INST_BITS  instruction words; slot i at bits [i*CPU_INST_BITS +: CPU_INST_BITS]
- ld_we  in  1  load-port write enable
- ld_addr  in  log2(DEPTH)  load-port word index
- ld_data  in  CPU_INST_BITS  load-port data

## Operation
- Accept: imem_req_val && imem_req_rdy. Word index idx = addr[2 +: log2(DEPTH)]; addr[1:0] ignored; upper bits ignored (wraps modulo DEPTH).
- Accepted index enters a LATENCY-stage valid/index shift pipeline. On exit, the array is read and the entry is pushed into the response FIFO (depth MAX_OUT): slot i = mem[(idx+i) mod DEPTH].
- Outstanding counter cnt (0..MAX_OUT): +1 on accept, -1 on delivery (imem_rec_val && imem_rec_rdy); both in one cycle leave it unchanged.
- imem_req_rdy = rst && !flush && (cnt < MAX_OUT). The FIFO can never overflow; no response is ever dropped except by flush.
- imem_rec_val = FIFO non-empty; imem_rec_packet = FIFO head, held stable while val && !rdy.
- Responses are strictly in request order.
- flush: next cycle, all pipeline valid bits, FIFO, and cnt are 0. No accept occurs in the flush cycle. A delivery in the flush cycle completes normally (the core owns that decision).
- Load port: mem[ld_addr] <= ld_data at the edge. A read in the same cycle as a write to the same word returns the old value. The array is not reset.

## Timing
- Reset (rst low, async): pipeline valids, FIFO pointers, and cnt cleared. imem_req_rdy=0, imem_rec_val=0, imem_rec_packet=0.
- First accept possible in the first cycle after rst deasserts.
- Accept at edge t -> imem_rec_val high after edge t+LATENCY if the FIFO is empty, i.e. during cycle t+LATENCY.
- Back-to-back: one accept per cycle sustained while the core keeps imem_rec_rdy high; throughput is 1 response/cycle.
- With imem_rec_rdy held low, exactly MAX_OUT requests are accepted, then imem_req_rdy drops. It rises the cycle after the first delivery.
- Full and drain in the same cycle: accept permitted only if cnt < MAX_OUT before the edge.
- FIFO pointer wrap-around is transparent; wrap of idx+i past DEPTH-1 returns mem[0...].

## Test plan
- Load mem[k]=0x1000+k for all k. Request addr 0x10 at t=0 with rdy high -> val at t=2, packet slot0=0x1004, slot1=0x1005.
- Request addresses 0x0, 0x8, 0x10, 0x18 back-to-back -> four responses on consecutive cycles starting t=2, in order, slot0 = 0x1000, 0x1002, 0x1004, 0x1006.
- imem_rec_rdy=0, hold val high -> exactly 4 accepts, then req_rdy=0. Packet stable. Raise rec_rdy for 1 cycle -> req_rdy=1 the next cycle.
- Request addr 4*(DEPTH-1)=0xFFC -> slot0=mem[1023], slot1=mem[0]. addr 0x1003 behaves as 0x1000 (idx 0 wrap).
- Two requests in flight, assert flush -> req_rdy=0 that cycle; no rec_val ever appears for them; cnt=0; a new request afterwards returns at +LATENCY.
- Assert rst mid-stream with 3 outstanding -> rec_val and req_rdy drop immediately. After release, no stale responses appear and memory contents are preserved.
